// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequence controller: stall/flush for PC, IF/ID, ID/EX plus MDU occupancy FSM and stall counter.
// Latency: all control outputs are combinational from current state and inputs (same cycle).
// Backpressure: load-use or MDU-busy HI/LO use holds PC and IF/ID and bubbles ID/EX; exception flush overrides.
module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mdu_start,
    input  logic             excp_flush,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic             mdu_overrun,
    output logic [CNT_W-1:0] stall_cycles
);

    // MDU_CYCLES-1 is the largest value the countdown ever holds
    localparam int               MCW      = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;
    localparam logic [MCW-1:0]   MDU_LOAD = MCW'(MDU_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    mdu_state_t       state_q, state_d;
    logic [MCW-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mdu_hz;
    logic stall;

    // Hazard detection and pipe-register controls; everything is gated low while reset is asserted
    always_comb begin
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
        mdu_hz   = (state_q == ST_BUSY) && id_uses_hilo;
        // An exception redirect kills the ID instruction, so there is nothing left to stall for
        stall    = (load_use || mdu_hz) && !excp_flush && rst_n;

        pc_stall = stall;
        fd_stall = stall;
        de_flush = (stall || excp_flush) && rst_n;
        // A taken branch is ignored while stalled: its operands are stale and ID resolves it again
        fd_flush = ((branch_taken && !stall) || excp_flush) && rst_n;
        mdu_busy = (state_q == ST_BUSY) && rst_n;
        // A flush cancels the op, so a DONE coinciding with it must not announce valid HI/LO
        mdu_done = (state_q == ST_DONE) && !excp_flush && rst_n;
    end

    // MDU occupancy next-state: IDLE -> BUSY (MDU_CYCLES-1 cycles) -> DONE (one cycle) -> IDLE
    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        overrun_d = overrun_q;

        // A second issue while busy means the interlock failed; remember it for debug
        if ((state_q == ST_BUSY) && mdu_start) begin
            overrun_d = 1'b1;
        end

        if (excp_flush) begin
            state_d   = ST_IDLE;
            mdu_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mdu_start) begin
                        state_d   = ST_BUSY;
                        mdu_cnt_d = MDU_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (mdu_cnt_q == MCW'(1)) begin
                        state_d   = ST_DONE;
                        mdu_cnt_d = '0;
                    end else begin
                        mdu_cnt_d = mdu_cnt_q - MCW'(1);
                    end
                end
                ST_DONE: begin
                    // Back-to-back issue is legal the cycle the previous result lands
                    if (mdu_start) begin
                        state_d   = ST_BUSY;
                        mdu_cnt_d = MDU_LOAD;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    mdu_cnt_d = '0;
                end
            endcase
        end
    end

    // Stall-cycle performance counter saturates instead of wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mdu_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            overrun_q   <= overrun_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mdu_overrun  = overrun_q;
    assign stall_cycles = stall_cnt_q;

endmodule
